pcie_cpl_gen: RTL and testbench
===============================

Name: pcie_cpl_gen

Overview:
Completer-side completion generator, directly downstream of the TLP receive stage. Consumes accepted request TLPs and emits completion TLPs on the same TLP-like field set: type, addr, len_dw, tag, cpl_status.
- Memory reads are split into Read-Completion-Boundary-aligned CplD chunks.
- Posted writes are absorbed.
- Malformed requests get a single status-only Cpl.

Parameters:
ADDR_W, 32, request/completion address width
LEN_W, 10, length field width in DW; encoding 0 means 1024 DW
TAG_W, 8, tag width
MAX_CPL_DW, 32, max completion payload and RCB in DW; power of 2, range 1..512
BC_W, LEN_W+3, byte-count width; unencoded, so 4096 is representable

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_type  in  3  type: 000 MRd, 001 MWr, 010 CplD, 011 Cpl, others reserved
req_addr  in  ADDR_W  byte address; bits [1:0] ignored and treated as 0
req_len_dw  in  LEN_W  length in DW
req_tag  in  TAG_W  requester tag
cpl_valid  out  1  completion present
cpl_ready  in  1  downstream accepts the completion
cpl_type  out  3  010 CplD or 011 Cpl
cpl_addr  out  ADDR_W  byte address of the first DW in this chunk
cpl_len_dw  out  LEN_W  chunk length; 0 for Cpl
cpl_byte_cnt  out  BC_W  bytes remaining, including this chunk; 0 for Cpl
cpl_tag  out  TAG_W  copied from the request
cpl_status  out  2  00 SC, 01 UR, 10 CA
busy  out  1  FSM is not in IDLE

Behaviour:
- Reset: every output is 0; FSM goes to IDLE. Reset is asynchronous, so it takes effect mid-operation and aborts any remaining chunks with no partial completion.
- req_ready is registered: 1 in IDLE, 0 otherwise and during reset. A request is accepted on an edge with req_valid && req_ready.
- FSM states:
  - IDLE: on accept, classify and register addr, tag and remaining length (len 0 maps to 1024).
    - MRd, in range -> EMIT.
    - MRd crossing 4KB (addr[11:0] + 4*len > 4096) -> ERR with CA.
    - Type 010, 011 or reserved -> ERR with UR.
    - MWr -> stays in IDLE; consumed, no output. req_ready stays 1.
  - EMIT: drives CplD, SC, cpl_addr = cur_addr, cpl_len_dw = chunk, cpl_byte_cnt = 4*remaining.
    - chunk = min(remaining, MAX_CPL_DW - (cur_addr[..2] mod MAX_CPL_DW)), which keeps every chunk end RCB-aligned.
    - On cpl_ready: cur_addr += 4*chunk, remaining -= chunk. If remaining becomes 0 -> IDLE, otherwise stay in EMIT.
  - ERR: drives a single Cpl with len 0 and byte_cnt 0; on cpl_ready -> IDLE.
- Latency:
  - First cpl_valid appears 1 cycle after request accept.
  - Consecutive chunks can issue back-to-back, one per cycle, while cpl_ready = 1.
  - req_ready returns 1 the cycle after the final completion handshake.
- Output handshake: cpl_valid stays asserted and all cpl_* fields stay stable until cpl_ready. cpl_valid never drops without a handshake, except on reset.
- Outputs are registered; cpl_* fields are don't-care while cpl_valid = 0 but must read 0 out of reset.
- Arithmetic: remaining is LEN_W+1 bits wide. The address increment wraps modulo 2^ADDR_W, but cannot cross 4KB because of the ERR check.

Decomposition:
- Package pcie_tlp_pkg:
  - tlp_type_e (MRD, MWR, CPLD, CPL)
  - cpl_status_e (SC, UR, CA)
  - constant PAGE_BYTES = 4096
  - the length-decode function (0 -> 1024)
- One combinational sub-module, pcie_cpl_chunk_calc: inputs cur_addr and remaining, output chunk. The FSM and registers stay in pcie_cpl_gen.

Test Plan:
1. MRd addr 0x1000, len 8, tag 0x05, cpl_ready = 1 -> one CplD: addr 0x1000, len 8, byte_cnt 32, tag 0x05, SC. cpl_valid appears 1 cycle after accept; req_ready is low until the handshake.
2. MRd addr 0x2070, len 40, tag 0x11 -> three CplDs:
   - addr 0x2070, len 4, byte_cnt 160
   - addr 0x2080, len 32, byte_cnt 144
   - addr 0x2100, len 4, byte_cnt 16
   - all carry tag 0x11, back-to-back on consecutive cycles.
3. MRd addr 0x3000, len 0 (1024 DW) -> 32 CplDs of len 32; byte_cnt runs 4096, 3968, ... down to 128; last addr 0x3F80.
4. MWr, then type 101 with tag 0x07, then MRd addr 0x0FF0 len 8 ->
   - MWr: no output, req_ready stays 1.
   - type 101: Cpl UR, len 0, byte_cnt 0, tag 0x07.
   - MRd crossing 4KB: Cpl CA, len 0, byte_cnt 0.
5. During chunk 2 of scenario 2, hold cpl_ready = 0 for 5 cycles -> cpl_valid stays 1 and all fields stay stable; chunk 3 follows the handshake.
6. Assert rst mid-EMIT of scenario 3 -> all outputs are 0 immediately. After release, req_ready = 1 on the first clock edge and no stale completions appear.

Source files
------------

// File: rtl/pcie_tlp_pkg.sv
// Shared TLP encodings, FSM states and helpers for the completion generator.
package pcie_tlp_pkg;

  typedef enum logic [2:0] {
    MRD  = 3'b000,
    MWR  = 3'b001,
    CPLD = 3'b010,
    CPL  = 3'b011
  } tlp_type_e;

  typedef enum logic [1:0] {
    SC = 2'b00,
    UR = 2'b01,
    CA = 2'b10
  } cpl_status_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_ERR
  } cpl_state_e;

  localparam int unsigned PAGE_BYTES = 4096;

  // A length field of zero encodes the maximum, 2^len_w DW.
  function automatic int unsigned decode_len(input int unsigned len_field,
                                             input int unsigned len_w);
    return (len_field == 0) ? (32'd1 << len_w) : len_field;
  endfunction

endpackage

// File: rtl/pcie_cpl_chunk_calc.sv
// Picks the next completion chunk so that every chunk ends on an RCB boundary.
module pcie_cpl_chunk_calc
  import pcie_tlp_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 10,
  parameter int MAX_CPL_DW = 32
) (
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [LEN_W:0]    remaining,
  output logic [LEN_W-1:0]  chunk
);

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(MAX_CPL_DW - 1);

  logic [ADDR_W-1:0] dw_addr;
  logic [LEN_W:0]    room;

  // Room left before the next RCB boundary, clipped to what is still owed.
  always_comb begin
    dw_addr = cur_addr >> 2;
    room    = (LEN_W+1)'(MAX_CPL_DW) - (LEN_W+1)'(dw_addr & OFF_MASK);
    chunk   = (remaining < room) ? LEN_W'(remaining) : LEN_W'(room);
  end

endmodule

// File: rtl/pcie_cpl_gen.sv
// Completer-side completion generator: splits MRd into RCB-aligned CplD
// chunks, swallows MWr, and answers malformed requests with one Cpl.
module pcie_cpl_gen
  import pcie_tlp_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 10,
  parameter int TAG_W      = 8,
  parameter int MAX_CPL_DW = 32,
  parameter int BC_W       = LEN_W + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len_dw,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              cpl_valid,
  input  logic              cpl_ready,
  output logic [2:0]        cpl_type,
  output logic [ADDR_W-1:0] cpl_addr,
  output logic [LEN_W-1:0]  cpl_len_dw,
  output logic [BC_W-1:0]   cpl_byte_cnt,
  output logic [TAG_W-1:0]  cpl_tag,
  output logic [1:0]        cpl_status,
  output logic              busy
);

  cpl_state_e        state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, addr_nxt, aligned_addr;
  logic [LEN_W:0]    remaining, rem_nxt, len_dec;
  logic [TAG_W-1:0]  tag_nxt;
  logic [1:0]        status_nxt;
  logic [2:0]        type_nxt;
  logic [LEN_W-1:0]  chunk_nxt, len_nxt;
  logic [BC_W-1:0]   bc_nxt;
  logic [31:0]       page_end;

  // The chunk is computed from next-cycle address/remaining so it can be registered.
  pcie_cpl_chunk_calc #(
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .MAX_CPL_DW(MAX_CPL_DW)
  ) u_chunk (
    .cur_addr (addr_nxt),
    .remaining(rem_nxt),
    .chunk    (chunk_nxt)
  );

  // Next-state decode plus next values for every registered output.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = cur_addr;
    rem_nxt      = remaining;
    tag_nxt      = cpl_tag;
    status_nxt   = cpl_status;
    aligned_addr = req_addr & ~ADDR_W'(3);
    len_dec      = (LEN_W+1)'(decode_len(32'(req_len_dw), LEN_W));
    page_end     = 32'(aligned_addr[11:0]) + 32'({len_dec, 2'b00});

    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          addr_nxt = aligned_addr;
          tag_nxt  = req_tag;
          case (req_type)
            MRD: begin
              if (page_end > PAGE_BYTES) begin
                state_nxt  = ST_ERR;
                status_nxt = CA;
                rem_nxt    = '0;
              end else begin
                state_nxt  = ST_EMIT;
                status_nxt = SC;
                rem_nxt    = len_dec;
              end
            end
            MWR: begin
              state_nxt = ST_IDLE;
            end
            default: begin
              state_nxt  = ST_ERR;
              status_nxt = UR;
              rem_nxt    = '0;
            end
          endcase
        end
      end
      ST_EMIT: begin
        if (cpl_ready) begin
          addr_nxt = cur_addr + ADDR_W'({cpl_len_dw, 2'b00});
          rem_nxt  = remaining - {1'b0, cpl_len_dw};
          if (rem_nxt == '0) state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (cpl_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    type_nxt = cpl_type;
    len_nxt  = '0;
    bc_nxt   = '0;
    if (state_nxt == ST_EMIT) begin
      type_nxt = CPLD;
      len_nxt  = chunk_nxt;
      bc_nxt   = {rem_nxt, 2'b00};
    end else if (state_nxt == ST_ERR) begin
      type_nxt = CPL;
    end
  end

  // State and output registers; reset aborts any in-flight completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cur_addr     <= '0;
      remaining    <= '0;
      req_ready    <= 1'b0;
      cpl_valid    <= 1'b0;
      cpl_type     <= '0;
      cpl_len_dw   <= '0;
      cpl_byte_cnt <= '0;
      cpl_tag      <= '0;
      cpl_status   <= '0;
    end else begin
      state        <= state_nxt;
      cur_addr     <= addr_nxt;
      remaining    <= rem_nxt;
      req_ready    <= (state_nxt == ST_IDLE);
      cpl_valid    <= (state_nxt != ST_IDLE);
      cpl_type     <= type_nxt;
      cpl_len_dw   <= len_nxt;
      cpl_byte_cnt <= bc_nxt;
      cpl_tag      <= tag_nxt;
      cpl_status   <= status_nxt;
    end
  end

  assign cpl_addr = cur_addr;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_pcie_cpl_gen.sv
// Directed bench for pcie_cpl_gen with hand-computed completion streams.
module tb_pcie_cpl_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [9:0]  req_len_dw;
  logic [7:0]  req_tag;
  logic        cpl_valid;
  logic        cpl_ready;
  logic [2:0]  cpl_type;
  logic [31:0] cpl_addr;
  logic [9:0]  cpl_len_dw;
  logic [12:0] cpl_byte_cnt;
  logic [7:0]  cpl_tag;
  logic [1:0]  cpl_status;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  pcie_cpl_gen dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_type    (req_type),
    .req_addr    (req_addr),
    .req_len_dw  (req_len_dw),
    .req_tag     (req_tag),
    .cpl_valid   (cpl_valid),
    .cpl_ready   (cpl_ready),
    .cpl_type    (cpl_type),
    .cpl_addr    (cpl_addr),
    .cpl_len_dw  (cpl_len_dw),
    .cpl_byte_cnt(cpl_byte_cnt),
    .cpl_tag     (cpl_tag),
    .cpl_status  (cpl_status),
    .busy        (busy)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] t, input logic [31:0] a,
                               input logic [9:0] l, input logic [7:0] g);
    req_valid  = 1'b1;
    req_type   = t;
    req_addr   = a;
    req_len_dw = l;
    req_tag    = g;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic checkCpl(input string name, input logic [2:0] t, input logic [31:0] a,
                          input logic [9:0] l, input logic [12:0] bc,
                          input logic [7:0] g, input logic [1:0] s);
    checkOutput({name, ".valid"}, 32'(cpl_valid), 32'd1);
    checkOutput({name, ".type"}, 32'(cpl_type), 32'(t));
    if (t == 3'b010) checkOutput({name, ".addr"}, cpl_addr, a);
    checkOutput({name, ".len"}, 32'(cpl_len_dw), 32'(l));
    checkOutput({name, ".bc"}, 32'(cpl_byte_cnt), 32'(bc));
    checkOutput({name, ".tag"}, 32'(cpl_tag), 32'(g));
    checkOutput({name, ".status"}, 32'(cpl_status), 32'(s));
    checkOutput({name, ".req_ready"}, 32'(req_ready), 32'd0);
    checkOutput({name, ".busy"}, 32'(busy), 32'd1);
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, ".valid"}, 32'(cpl_valid), 32'd0);
    checkOutput({name, ".req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({name, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, ".req_ready"}, 32'(req_ready), 32'd0);
    checkOutput({name, ".valid"}, 32'(cpl_valid), 32'd0);
    checkOutput({name, ".type"}, 32'(cpl_type), 32'd0);
    checkOutput({name, ".addr"}, cpl_addr, 32'd0);
    checkOutput({name, ".len"}, 32'(cpl_len_dw), 32'd0);
    checkOutput({name, ".bc"}, 32'(cpl_byte_cnt), 32'd0);
    checkOutput({name, ".tag"}, 32'(cpl_tag), 32'd0);
    checkOutput({name, ".status"}, 32'(cpl_status), 32'd0);
    checkOutput({name, ".busy"}, 32'(busy), 32'd0);
  endtask

  // Directed sequence covering the completion scenarios one after another.
  initial begin
    logic [31:0] s2_addr [3];
    logic [9:0]  s2_len  [3];
    logic [12:0] s2_bc   [3];
    s2_addr = '{32'h2070, 32'h2080, 32'h2100};
    s2_len  = '{10'd4, 10'd32, 10'd4};
    s2_bc   = '{13'd160, 13'd144, 13'd16};

    rst = 1'b1; req_valid = 1'b0; req_type = '0; req_addr = '0;
    req_len_dw = '0; req_tag = '0; cpl_ready = 1'b1;
    #1;
    checkAllZero("reset");
    step();
    checkAllZero("reset_held");
    #2 rst = 1'b0;
    step();
    checkIdle("post_reset");

    // Single-chunk read.
    applyStimulus(3'b000, 32'h1000, 10'd8, 8'h05);
    checkCpl("s1", 3'b010, 32'h1000, 10'd8, 13'd32, 8'h05, 2'b00);
    step();
    checkIdle("s1_done");

    // Three chunks straddling RCB boundaries, back to back.
    applyStimulus(3'b000, 32'h2070, 10'd40, 8'h11);
    for (int i = 0; i < 3; i++) begin
      checkCpl($sformatf("s2_c%0d", i), 3'b010, s2_addr[i], s2_len[i], s2_bc[i], 8'h11, 2'b00);
      step();
    end
    checkIdle("s2_done");

    // Full 1024 DW read from a page start.
    applyStimulus(3'b000, 32'h3000, 10'd0, 8'h22);
    for (int i = 0; i < 32; i++) begin
      checkCpl($sformatf("s3_c%0d", i), 3'b010, 32'h3000 + 32'(128 * i), 10'd32,
               13'(4096 - 128 * i), 8'h22, 2'b00);
      step();
    end
    checkIdle("s3_done");

    // Posted write, reserved type, and a 4KB-crossing read.
    applyStimulus(3'b001, 32'h4000, 10'd4, 8'h33);
    checkIdle("s4_mwr");
    applyStimulus(3'b101, 32'h5000, 10'd4, 8'h07);
    checkCpl("s4_ur", 3'b011, 32'h0, 10'd0, 13'd0, 8'h07, 2'b01);
    step();
    checkIdle("s4_ur_done");
    applyStimulus(3'b000, 32'h0FF0, 10'd8, 8'h44);
    checkCpl("s4_ca", 3'b011, 32'h0, 10'd0, 13'd0, 8'h44, 2'b10);
    step();
    checkIdle("s4_ca_done");

    // Backpressure on the second chunk.
    applyStimulus(3'b000, 32'h2070, 10'd40, 8'h11);
    checkCpl("s5_c0", 3'b010, 32'h2070, 10'd4, 13'd160, 8'h11, 2'b00);
    step();
    cpl_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkCpl($sformatf("s5_hold%0d", i), 3'b010, 32'h2080, 10'd32, 13'd144, 8'h11, 2'b00);
      step();
    end
    checkCpl("s5_hold5", 3'b010, 32'h2080, 10'd32, 13'd144, 8'h11, 2'b00);
    cpl_ready = 1'b1;
    step();
    checkCpl("s5_c2", 3'b010, 32'h2100, 10'd4, 13'd16, 8'h11, 2'b00);
    step();
    checkIdle("s5_done");

    // Asynchronous reset in the middle of a long read.
    applyStimulus(3'b000, 32'h3000, 10'd0, 8'h22);
    step(); step(); step();
    checkCpl("s6_pre", 3'b010, 32'h3180, 10'd32, 13'd3712, 8'h22, 2'b00);
    #1 rst = 1'b1;
    #1;
    checkAllZero("s6_rst");
    #1 rst = 1'b0;
    step();
    checkIdle("s6_release");
    for (int i = 0; i < 3; i++) begin
      step();
      checkIdle($sformatf("s6_quiet%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
